alu_mult_seq: RTL and testbench

//  Parametrised sequential shift-add multiplier, successor to the 5-bit combinational ALU multiplier.

---
 rtl/alu_mult_seq_if.sv | 36 +++
 rtl/alu_mult_seq.sv | 120 ++++++++++++
 tb/tb_alu_mult_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_mult_seq_if.sv
// Handshake bundle for the sequential multiplier: operand request channel,
// result response channel and a busy status flag.
// Optional signed mode (ALU_MULT_SIGNED_EN) adds the is_signed request bit.
interface alu_mult_seq_if #(
  parameter int WIDTH = 5
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       operand_a;
  logic [WIDTH-1:0]       operand_b;
`ifdef ALU_MULT_SIGNED_EN
  logic                   is_signed;
`endif
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     result;
  logic                   busy;

  // Producer of operands / consumer of results.
  modport master (
`ifdef ALU_MULT_SIGNED_EN
    output is_signed,
`endif
    output in_valid, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  // The multiplier itself.
  modport slave (
`ifdef ALU_MULT_SIGNED_EN
    input  is_signed,
`endif
    input  in_valid, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/alu_mult_seq.sv
// Sequential shift-add multiplier: one multiplier bit retired per clock,
// WIDTH iterations per operation regardless of operand values.
// Optional feature macro: ALU_MULT_SIGNED_EN (two's-complement mode via is_signed).
module alu_mult_seq #(
  parameter int WIDTH = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_mult_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_reg, state_next;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [2*WIDTH-1:0]   a_sh_reg;     // multiplicand, shifted left once per iteration
  logic [WIDTH-1:0]     b_sh_reg;     // multiplier, shifted right so bit 0 is the current bit
  logic [CNT_W-1:0]     count_reg;
  logic [2*WIDTH-1:0]   result_reg;
  logic [2*WIDTH-1:0]   sum;
  logic [2*WIDTH-1:0]   final_prod;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic                 accept;
`ifdef ALU_MULT_SIGNED_EN
  logic                 neg_reg;
  logic                 neg_in;
`endif

  assign accept = (state_reg == IDLE) && bus.in_valid;
  assign sum    = acc_reg + (b_sh_reg[0] ? a_sh_reg : '0);

`ifdef ALU_MULT_SIGNED_EN
  // Form operand magnitudes at accept; the most-negative value maps to 2^(WIDTH-1), which fits unsigned.
  always_comb begin
    mag_a  = bus.operand_a;
    mag_b  = bus.operand_b;
    neg_in = 1'b0;
    if (bus.is_signed) begin
      if (bus.operand_a[WIDTH-1]) mag_a = ~bus.operand_a + WIDTH'(1);
      if (bus.operand_b[WIDTH-1]) mag_b = ~bus.operand_b + WIDTH'(1);
      neg_in = bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
    end
  end

  // Apply the product sign on the way into the result register.
  always_comb begin
    final_prod = neg_reg ? (~sum + (2*WIDTH)'(1)) : sum;
  end
`else
  // Unsigned-only build: operands pass straight through.
  always_comb begin
    mag_a      = bus.operand_a;
    mag_b      = bus.operand_b;
    final_prod = sum;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and handshake outputs; in_ready is IDLE-only so no accept can coincide with a result transfer.
  always_comb begin
    state_next    = state_reg;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = BUSY;
      end
      BUSY: begin
        bus.busy = 1'b1;
        if (count_reg == LAST_CNT) state_next = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.result = result_reg;

  // Datapath: latch operands on accept, then one conditional add and shift per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      count_reg  <= '0;
      result_reg <= '0;
`ifdef ALU_MULT_SIGNED_EN
      neg_reg    <= 1'b0;
`endif
    end else if (accept) begin
      acc_reg   <= '0;
      a_sh_reg  <= {{WIDTH{1'b0}}, mag_a};
      b_sh_reg  <= mag_b;
      count_reg <= '0;
`ifdef ALU_MULT_SIGNED_EN
      neg_reg   <= neg_in;
`endif
    end else if (state_reg == BUSY) begin
      acc_reg   <= sum;
      a_sh_reg  <= a_sh_reg << 1;
      b_sh_reg  <= b_sh_reg >> 1;
      count_reg <= count_reg + CNT_W'(1);
      if (count_reg == LAST_CNT) result_reg <= final_prod;
    end
  end
endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq at WIDTH=5, plus a WIDTH=8 instance
// exercised with 255*255 and random operands under random handshakes.
module tb_alu_mult_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  alu_mult_seq_if #(.WIDTH(5)) m5 ();
  alu_mult_seq_if #(.WIDTH(8)) m8 ();

  alu_mult_seq #(.WIDTH(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(m5.slave));
  alu_mult_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(m8.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand pair, accept it, and measure cycles until out_valid.
  task automatic start_op(input string tag, input logic [4:0] a, input logic [4:0] b);
    int cyc;
    m5.operand_a = a;
    m5.operand_b = b;
    m5.in_valid  = 1'b1;
    chk({tag, "_in_ready"}, 32'(m5.in_ready), 32'd1);
    tick();
    m5.in_valid  = 1'b0;
    m5.operand_a = ~a;   // later changes must not affect the op in flight
    m5.operand_b = ~b;
    chk({tag, "_busy"}, 32'(m5.busy), 32'd1);
    cyc = 0;
    while (!m5.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd5);
  endtask

  // Check the product, transfer it, and confirm the return to IDLE.
  task automatic finish_op(input string tag, input logic [9:0] exp);
    chk({tag, "_result"}, 32'(m5.result), 32'(exp));
    m5.out_ready = 1'b1;
    tick();
    m5.out_ready = 1'b0;
    chk({tag, "_out_valid_low"}, 32'(m5.out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(m5.in_ready), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [4:0] a, input logic [4:0] b, input logic [9:0] exp);
    start_op(tag, a, b);
    finish_op(tag, exp);
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic [15:0] rexp;
    int          cnt;
    bit          done;

    m5.in_valid = 1'b0; m5.operand_a = '0; m5.operand_b = '0; m5.out_ready = 1'b0;
    m8.in_valid = 1'b0; m8.operand_a = '0; m8.operand_b = '0; m8.out_ready = 1'b0;
`ifdef ALU_MULT_SIGNED_EN
    m5.is_signed = 1'b0;
    m8.is_signed = 1'b0;
`endif
    #22;
    chk("rst_in_ready", 32'(m5.in_ready), 32'd1);
    chk("rst_out_valid", 32'(m5.out_valid), 32'd0);
    chk("rst_busy", 32'(m5.busy), 32'd0);
    chk("rst_result", 32'(m5.result), 32'd0);
    rst_n = 1'b1;
    tick();

    do_op("31x31", 5'd31, 5'd31, 10'd961);
    do_op("0x27", 5'd0, 5'd27, 10'd0);
    do_op("19x0", 5'd19, 5'd0, 10'd0);
    do_op("1x1", 5'd1, 5'd1, 10'd1);

    // Stall in DONE for 10 cycles.
    start_op("stall", 5'd31, 5'd31);
    repeat (10) tick();
    chk("stall_out_valid", 32'(m5.out_valid), 32'd1);
    chk("stall_result", 32'(m5.result), 32'd961);
    chk("stall_in_ready", 32'(m5.in_ready), 32'd0);
    finish_op("stall", 10'd961);
    do_op("7x9", 5'd7, 5'd9, 10'd63);

    // Reset on the second BUSY cycle abandons the op.
    m5.operand_a = 5'd5; m5.operand_b = 5'd6; m5.in_valid = 1'b1;
    tick();
    m5.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(m5.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(m5.in_ready), 32'd1);
    chk("midrst_busy", 32'(m5.busy), 32'd0);
    chk("midrst_result", 32'(m5.result), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    do_op("12x13", 5'd12, 5'd13, 10'd156);

`ifdef ALU_MULT_SIGNED_EN
    m5.is_signed = 1'b1;
    do_op("s_m16xm16", 5'h10, 5'h10, 10'h100);
    do_op("s_m1x15", 5'h1F, 5'h0F, 10'h3F1);
    do_op("s_7xm3", 5'h07, 5'h1D, 10'h3EB);
    m5.is_signed = 1'b0;
    do_op("u_1Fx1F", 5'h1F, 5'h1F, 10'd961);
`endif

    // WIDTH=8: 255*255 first, then random operands with random handshake timing.
    for (int i = 0; i < 1000; i++) begin
      if (i == 0) begin
        ra = 8'd255; rb = 8'd255;
      end else begin
        ra = 8'($urandom); rb = 8'($urandom);
      end
      rexp = 16'(ra) * 16'(rb);
      repeat ($urandom_range(0, 3)) tick();
      m8.operand_a = ra;
      m8.operand_b = rb;
      m8.in_valid  = 1'b1;
      cnt = 0;
      while (!m8.in_ready && cnt < 50) begin
        tick();
        cnt++;
      end
      tick();
      m8.in_valid  = 1'b0;
      m8.operand_a = 8'($urandom);
      m8.operand_b = 8'($urandom);
      cnt  = 0;
      done = 1'b0;
      while (!done && cnt < 100) begin
        m8.out_ready = 1'($urandom);
        if (m8.out_valid && m8.out_ready) begin
          chk($sformatf("w8_op%0d_%0dx%0d", i, ra, rb), 32'(m8.result), 32'(rexp));
          done = 1'b1;
        end
        tick();
        cnt++;
      end
      m8.out_ready = 1'b0;
      if (!done) chk($sformatf("w8_op%0d_timeout", i), 32'd0, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
